// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave for an MCP3204-style 12-bit ADC.
// A start bit and a 4-bit control word select a channel or channel pair.
// The block snapshots the selected result and shifts it out MSB first after a null bit.
// The SPI pins are asynchronous to clk, so they are synchronized and their edges are detected in the clk domain.
module adc_spi_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [11:0] ch0,
    input  logic [11:0] ch1,
    input  logic [11:0] ch2,
    input  logic [11:0] ch3,
    output logic        last_sgl,
    output logic [1:0]  last_ch,
    output logic        conv_done,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CTRL,
        XFER,
        DONE
    } state_t;

    // Synchronizer stages plus one extra delayed copy for edge detection.
    logic cs_meta, cs_sync, cs_prev;
    logic sclk_meta, sclk_sync, sclk_prev;
    logic mosi_meta, mosi_sync;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    // Registered state and the next-state values computed combinationally.
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  ctrl_q, ctrl_d;      // {SGL, D2, D1, D0} once all four bits are in
    logic [11:0] shreg_q, shreg_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        conv_done_q, conv_done_d;
    logic        frame_err_q, frame_err_d;
    logic        last_sgl_q, last_sgl_d;
    logic [1:0]  last_ch_q, last_ch_d;

    logic [11:0] result;
    logic [11:0] single_val, pos_val, neg_val;
    logic [12:0] diff;
    logic [1:0]  sel;

    // Double-flop synchronizers for the asynchronous SPI pins, plus a delayed copy for edge detection.
    // NOTE: sequential state uses non-blocking assignments so that each flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            cs_meta   <= cs_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    assign cs_rise   = cs_sync & ~cs_prev;
    assign cs_fall   = ~cs_sync & cs_prev;

    // Conversion result for the word being completed.
    // D0 arrives on mosi during the rise that completes the word.
    // SGL and D1 are already held in ctrl_q.
    // NOTE: every variable written in an always_comb block gets a default first, so no latch is inferred.
    always_comb begin
        sel        = {ctrl_q[0], mosi_sync};
        single_val = 12'h000;
        pos_val    = 12'h000;
        neg_val    = 12'h000;
        case (sel)
            2'b00: begin single_val = ch0; pos_val = ch0; neg_val = ch1; end
            2'b01: begin single_val = ch1; pos_val = ch1; neg_val = ch0; end
            2'b10: begin single_val = ch2; pos_val = ch2; neg_val = ch3; end
            default: begin single_val = ch3; pos_val = ch3; neg_val = ch2; end
        endcase
        // The 13-bit difference keeps a borrow bit, so a negative result is detected instead of wrapping.
        diff = {1'b0, pos_val} - {1'b0, neg_val};
        if (ctrl_q[2]) begin
            result = single_val;
        end else if (diff[12]) begin
            result = 12'h000;
        end else begin
            result = diff[11:0];
        end
    end

    // Frame state register and all datapath/output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ctrl_q      <= 4'd0;
            shreg_q     <= 12'h000;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            conv_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            last_sgl_q  <= 1'b0;
            last_ch_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            shreg_q     <= shreg_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            conv_done_q <= conv_done_d;
            frame_err_q <= frame_err_d;
            last_sgl_q  <= last_sgl_d;
            last_ch_q   <= last_ch_d;
        end
    end

    // Next-state and output logic.
    // A cs_n rise overrides any sclk edge detected in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        shreg_d     = shreg_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        conv_done_d = 1'b0;
        frame_err_d = 1'b0;
        last_sgl_d  = last_sgl_q;
        last_ch_d   = last_ch_q;

        if (cs_rise && (state_q != IDLE)) begin
            state_d     = IDLE;
            cnt_d       = 4'd0;
            ctrl_d      = 4'd0;
            shreg_d     = 12'h000;
            miso_d      = 1'b0;
            oe_d        = 1'b0;
            // A frame counts as aborted only if the master quits before B0 has gone out.
            frame_err_d = (state_q == CTRL) || (state_q == XFER);
        end else begin
            case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                    cnt_d  = 4'd0;
                    if (cs_fall) begin
                        state_d = WAIT_START;
                    end
                end
                WAIT_START: begin
                    // Leading zeros before the start bit are skipped.
                    if (sclk_rise && mosi_sync) begin
                        state_d = CTRL;
                        cnt_d   = 4'd0;
                    end
                end
                CTRL: begin
                    if (sclk_rise) begin
                        ctrl_d = {ctrl_q[2:0], mosi_sync};
                        if (cnt_q == 4'd3) begin
                            // Snapshot now so later channel changes cannot disturb the frame.
                            shreg_d = result;
                            state_d = XFER;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                XFER: begin
                    if (sclk_fall) begin
                        oe_d = 1'b1;
                        if (cnt_q == 4'd0) begin
                            miso_d = 1'b0;
                            cnt_d  = 4'd1;
                        end else begin
                            miso_d  = shreg_q[11];
                            shreg_d = {shreg_q[10:0], 1'b0};
                            if (cnt_q == 4'd12) begin
                                conv_done_d = 1'b1;
                                last_sgl_d  = ctrl_q[3];
                                last_ch_d   = ctrl_q[1:0];
                                state_d     = DONE;
                                cnt_d       = 4'd0;
                            end else begin
                                cnt_d = cnt_q + 4'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (sclk_fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = oe_q;
    assign conv_done = conv_done_q;
    assign frame_err = frame_err_q;
    assign last_sgl  = last_sgl_q;
    assign last_ch   = last_ch_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: bench for adc_spi_responder.
// Models an SPI mode-0 master and keeps a scoreboard of the expected {miso_oe, miso} samples.
`timescale 1ns/1ps
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [11:0] ch0, ch1, ch2, ch3;
    logic        last_sgl;
    logic [1:0]  last_ch;
    logic        conv_done;
    logic        frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int conv_hi  = 0;
    int ferr_hi  = 0;
    logic       snap_sgl = 1'b0;
    logic [1:0] snap_ch  = 2'd0;
    logic [1:0] exp_q[$];

    adc_spi_responder dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .ch0       (ch0),
        .ch1       (ch1),
        .ch2       (ch2),
        .ch3       (ch3),
        .last_sgl  (last_sgl),
        .last_ch   (last_ch),
        .conv_done (conv_done),
        .frame_err (frame_err)
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    // Pulse monitor: counts conv_done and frame_err cycles and captures last_* during conv_done.
    always @(negedge clk) begin
        if (conv_done) begin
            conv_hi  = conv_hi + 1;
            snap_sgl = last_sgl;
            snap_ch  = last_ch;
        end
        if (frame_err) begin
            ferr_hi = ferr_hi + 1;
        end
    end

    // Safety net so the run always terminates.
    initial begin
        #1800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference conversion, computed with signed integer arithmetic.
    function automatic logic [11:0] model(input logic sgl, input logic [1:0] sel);
        int a;
        int b;
        int d;
        case (sel)
            2'b00: begin a = int'(ch0); b = int'(ch1); end
            2'b01: begin a = int'(ch1); b = int'(ch0); end
            2'b10: begin a = int'(ch2); b = int'(ch3); end
            default: begin a = int'(ch3); b = int'(ch2); end
        endcase
        if (sgl) begin
            return a[11:0];
        end
        d = a - b;
        if (d < 0) begin
            d = 0;
        end
        return d[11:0];
    endfunction

    // Expected {miso_oe, miso} seen by the master just before rise i.
    function automatic logic [1:0] exp_sample(input int i, input int lead, input logic [11:0] word);
        int s;
        s = lead + 4;
        if (i <= s) return 2'b00;
        if (i == s + 1) return 2'b10;
        if (i <= s + 13) return {1'b1, word[11 - (i - s - 2)]};
        return 2'b10;
    endfunction

    // Drive one frame of ncyc sclk cycles with cs_n left low at the end.
    // When scramble is set, the channel inputs are inverted after the snapshot and restored afterwards.
    task automatic run_frame(input int lead, input logic sgl, input logic d2, input logic [1:0] sel,
                             input int ncyc, input int half, input logic scramble);
        logic [11:0] word;
        logic [11:0] s0, s1, s2, s3;
        word = model(sgl, sel);
        s0 = ch0; s1 = ch1; s2 = ch2; s3 = ch3;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < ncyc; i++) begin
            if (i < lead)           mosi = 1'b0;
            else if (i == lead)     mosi = 1'b1;
            else if (i == lead + 1) mosi = sgl;
            else if (i == lead + 2) mosi = d2;
            else if (i == lead + 3) mosi = sel[1];
            else if (i == lead + 4) mosi = sel[0];
            else                    mosi = 1'b0;
            exp_q.push_back(exp_sample(i, lead, word));
            repeat (half) @(negedge clk);
            if (scramble && i == lead + 6) begin
                ch0 = ~ch0; ch1 = ~ch1; ch2 = ~ch2; ch3 = ~ch3;
            end
            check($sformatf("miso[%0d]", i), {30'd0, miso_oe, miso}, {30'd0, exp_q.pop_front()});
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        ch0 = s0; ch1 = s1; ch2 = s2; ch3 = s3;
    endtask

    // Raise cs_n and require the bus to be released within 4 clk cycles.
    task automatic end_frame();
        @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        #75;
        check("oe_release", {31'd0, miso_oe}, 32'd0);
        check("miso_release", {31'd0, miso}, 32'd0);
        repeat (10) @(negedge clk);
    endtask

    // Check the conv_done/frame_err counts and the last_* values, both as captured during conv_done and afterwards.
    task automatic frame_checks(input string tag, input int conv0, input int ferr0, input int conv_exp,
                                input int ferr_exp, input logic sgl, input logic [1:0] sel);
        check({tag, "_conv_done"}, conv_hi - conv0, conv_exp);
        check({tag, "_frame_err"}, ferr_hi - ferr0, ferr_exp);
        if (conv_exp != 0) begin
            check({tag, "_snap_sgl"}, {31'd0, snap_sgl}, {31'd0, sgl});
            check({tag, "_snap_ch"}, {30'd0, snap_ch}, {30'd0, sel});
            check({tag, "_last_sgl"}, {31'd0, last_sgl}, {31'd0, sgl});
            check({tag, "_last_ch"}, {30'd0, last_ch}, {30'd0, sel});
        end
    endtask

    initial begin
        int c0;
        int f0;
        rst  = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        ch0 = 12'hA5C; ch1 = 12'h123; ch2 = 12'h300; ch3 = 12'h100;
        #55;
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_conv_done", {31'd0, conv_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_last_sgl", {31'd0, last_sgl}, 32'd0);
        check("rst_last_ch", {30'd0, last_ch}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single-ended ch0 at 100 kHz, control bits 1,1,0,0,0.
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(0, 1'b1, 1'b0, 2'b00, 18, 250, 1'b0);
        end_frame();
        frame_checks("f1", c0, f0, 1, 0, 1'b1, 2'b00);

        // Differential ch2-ch3 with channels scrambled mid-frame, then swapped to a clamped negative.
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(0, 1'b0, 1'b1, 2'b10, 18, 60, 1'b1);
        end_frame();
        frame_checks("f2", c0, f0, 1, 0, 1'b0, 2'b10);
        ch2 = 12'h100; ch3 = 12'h300;
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(0, 1'b0, 1'b0, 2'b10, 18, 60, 1'b0);
        end_frame();
        frame_checks("f3", c0, f0, 1, 0, 1'b0, 2'b10);

        // Two leading zeros before the start bit, single-ended ch3 = FFF.
        ch3 = 12'hFFF;
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(2, 1'b1, 1'b1, 2'b11, 20, 60, 1'b0);
        end_frame();
        frame_checks("f4", c0, f0, 1, 0, 1'b1, 2'b11);

        // Abort after six data bits.
        ch1 = 12'h3C7;
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(0, 1'b1, 1'b0, 2'b01, 12, 60, 1'b0);
        end_frame();
        frame_checks("f5", c0, f0, 0, 1, 1'b1, 2'b01);

        // Full frame following the abort: ch0-ch1.
        ch0 = 12'h800; ch1 = 12'h123;
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(0, 1'b0, 1'b0, 2'b00, 18, 60, 1'b0);
        end_frame();
        frame_checks("f6", c0, f0, 1, 0, 1'b0, 2'b00);

        // Over-long frame of 20 sclk cycles: trailing zeros, no frame_err.
        ch2 = 12'h5A5;
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(0, 1'b1, 1'b0, 2'b10, 20, 60, 1'b0);
        end_frame();
        frame_checks("f7", c0, f0, 1, 0, 1'b1, 2'b10);

        // Reset pulse while B5 is on the bus.
        ch2 = 12'h1FF; ch3 = 12'h400;
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(0, 1'b0, 1'b0, 2'b11, 12, 60, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_rst_oe", {31'd0, miso_oe}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_miso", {31'd0, miso}, 32'd0);
        check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
        check("mid_rst_conv_done", {31'd0, conv_done}, 32'd0);
        check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("mid_rst_last_sgl", {31'd0, last_sgl}, 32'd0);
        check("mid_rst_last_ch", {30'd0, last_ch}, 32'd0);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        frame_checks("f8", c0, f0, 0, 0, 1'b0, 2'b11);

        // Frame after the reset.
        ch1 = 12'h0F0;
        c0 = conv_hi; f0 = ferr_hi;
        run_frame(0, 1'b1, 1'b0, 2'b01, 18, 60, 1'b0);
        end_frame();
        frame_checks("f9", c0, f0, 1, 0, 1'b1, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
